// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: SPI-slave command decoder and frame-RAM pixel sequencer, SCLK domain.
// Revision: 1.0
`default_nettype none

module spi_frame_sequencer #(
    parameter logic [7:0] DEV_ID      = 8'h64,
    parameter int         FRAME_BYTES = 4096
) (
    input  logic        SCLK,
    input  logic        RST,
    input  logic        CS_N,
    input  logic        MOSI,
    output logic        MISO,
    output logic [11:0] PIX_ADDR,
    output logic        PIX_RE,
    input  logic [7:0]  PIX_DATA,
    output logic        TP_EN,
    output logic [5:0]  ROW_START,
    output logic        FRAME_DONE
);

    localparam logic [2:0] ST_CMD      = 3'd0;
    localparam logic [2:0] ST_DUMMY    = 3'd1;
    localparam logic [2:0] ST_STREAM   = 3'd2;
    localparam logic [2:0] ST_REG_ADDR = 3'd3;
    localparam logic [2:0] ST_REG_DATA = 3'd4;
    localparam logic [2:0] ST_RESP     = 3'd5;
    localparam logic [2:0] ST_IGNORE   = 3'd6;

    localparam logic [7:0]  CMD_READ_FRAME  = 8'h01;
    localparam logic [7:0]  CMD_WRITE_REG   = 8'h02;
    localparam logic [7:0]  CMD_READ_STATUS = 8'h03;
    localparam logic [7:0]  CMD_READ_ID     = 8'h9F;
    localparam logic [11:0] LAST_OFFSET     = 12'(FRAME_BYTES - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  resp_q, resp_d;
    logic [11:0] ptr_q, ptr_d;
    logic [11:0] pix_off_q, pix_off_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [11:0] pix_addr_q, pix_addr_d;
    logic        pix_re_q, pix_re_d;
    logic        frame_done_q, frame_done_d;
    logic        tp_en_q, tp_en_d;
    logic [5:0]  row_start_q, row_start_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic [7:0]  w_byte;
    logic        w_last_bit;
    logic        w_pix_state;
    logic [11:0] w_frame_base;
    logic [7:0]  w_tp_byte;

    assign w_byte       = {rx_shift_q, MOSI};
    assign w_last_bit   = (bit_cnt_q == 3'd7);
    assign w_pix_state  = (state_q == ST_DUMMY) || (state_q == ST_STREAM);
    assign w_frame_base = {row_start_q, 6'd0};
    assign w_tp_byte    = {ptr_q[9:6], ptr_q[3:0]};

    // Transaction state: cleared by reset and whenever the host deselects.
    always_ff @(posedge SCLK or posedge RST or posedge CS_N) begin
        if (RST || CS_N) begin
            state_q      <= ST_CMD;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 7'd0;
            tx_shift_q   <= 8'd0;
            resp_q       <= 8'd0;
            ptr_q        <= 12'd0;
            pix_off_q    <= 12'd0;
            reg_addr_q   <= 8'd0;
            pix_addr_q   <= 12'd0;
            pix_re_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            resp_q       <= resp_d;
            ptr_q        <= ptr_d;
            pix_off_q    <= pix_off_d;
            reg_addr_q   <= reg_addr_d;
            pix_addr_q   <= pix_addr_d;
            pix_re_q     <= pix_re_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Configuration and frame count survive deselection.
    always_ff @(posedge SCLK or posedge RST) begin
        if (RST) begin
            tp_en_q     <= 1'b0;
            row_start_q <= 6'd0;
            frame_cnt_q <= 8'd0;
        end else begin
            tp_en_q     <= tp_en_d;
            row_start_q <= row_start_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (w_last_bit) begin
            case (state_q)
                ST_CMD: begin
                    case (w_byte)
                        CMD_READ_FRAME:  state_d = ST_DUMMY;
                        CMD_WRITE_REG:   state_d = ST_REG_ADDR;
                        CMD_READ_STATUS: state_d = ST_RESP;
                        CMD_READ_ID:     state_d = ST_RESP;
                        default:         state_d = ST_IGNORE;
                    endcase
                end
                ST_DUMMY:    state_d = ST_STREAM;
                ST_REG_ADDR: state_d = ST_REG_DATA;
                ST_REG_DATA: state_d = ST_IGNORE;
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d    = bit_cnt_q + 3'd1;
        rx_shift_d   = w_byte[6:0];
        tx_shift_d   = {tx_shift_q[6:0], 1'b0};
        resp_d       = resp_q;
        ptr_d        = ptr_q;
        pix_off_d    = pix_off_q;
        reg_addr_d   = reg_addr_q;
        pix_addr_d   = pix_addr_q;
        pix_re_d     = 1'b0;
        frame_done_d = 1'b0;
        tp_en_d      = tp_en_q;
        row_start_d  = row_start_q;
        frame_cnt_d  = frame_cnt_q;

        // Address goes out on bit 5 so RAM data is ready for the bit-7 load.
        if (w_pix_state && (bit_cnt_q == 3'd5) && !tp_en_q) begin
            pix_addr_d = ptr_q;
            pix_re_d   = 1'b1;
        end

        if (w_last_bit) begin
            tx_shift_d = 8'h00;
            case (state_q)
                ST_CMD: begin
                    case (w_byte)
                        CMD_READ_FRAME: begin
                            ptr_d     = w_frame_base;
                            pix_off_d = 12'd0;
                        end
                        CMD_READ_STATUS: begin
                            resp_d     = {tp_en_q, frame_cnt_q[6:0]};
                            tx_shift_d = {tp_en_q, frame_cnt_q[6:0]};
                        end
                        CMD_READ_ID: begin
                            resp_d     = DEV_ID;
                            tx_shift_d = DEV_ID;
                        end
                        default: ;
                    endcase
                end
                ST_DUMMY, ST_STREAM: begin
                    tx_shift_d = tp_en_q ? w_tp_byte : PIX_DATA;
                    if (pix_off_q == LAST_OFFSET) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        ptr_d        = w_frame_base;
                        pix_off_d    = 12'd0;
                    end else begin
                        ptr_d     = ptr_q + 12'd1;
                        pix_off_d = pix_off_q + 12'd1;
                    end
                end
                ST_REG_ADDR: reg_addr_d = w_byte;
                ST_REG_DATA: begin
                    if (reg_addr_q == 8'h00) begin
                        tp_en_d = w_byte[0];
                    end else if (reg_addr_q == 8'h01) begin
                        row_start_d = w_byte[5:0];
                    end
                end
                ST_RESP: tx_shift_d = resp_q;
                default: ;
            endcase
        end
    end

    assign MISO       = tx_shift_q[7];
    assign PIX_ADDR   = pix_addr_q;
    assign PIX_RE     = pix_re_q;
    assign TP_EN      = tp_en_q;
    assign ROW_START  = row_start_q;
    assign FRAME_DONE = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_sequencer.sv
// tb_spi_frame_sequencer: randomized SPI transactions checked per cycle against a transaction-level model.
// Revision: 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_spi_frame_sequencer;

    localparam int MAXB = 4200;
    localparam int MAXC = MAXB * 8 + 1;

    logic        SCLK = 1'b0;
    logic        RST  = 1'b1;
    logic        CS_N = 1'b1;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [11:0] PIX_ADDR;
    logic        PIX_RE;
    logic [7:0]  PIX_DATA;
    logic        TP_EN;
    logic [5:0]  ROW_START;
    logic        FRAME_DONE;

    always #5 SCLK = ~SCLK;

    spi_frame_sequencer dut (
        .SCLK       (SCLK),
        .RST        (RST),
        .CS_N       (CS_N),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .PIX_ADDR   (PIX_ADDR),
        .PIX_RE     (PIX_RE),
        .PIX_DATA   (PIX_DATA),
        .TP_EN      (TP_EN),
        .ROW_START  (ROW_START),
        .FRAME_DONE (FRAME_DONE)
    );

    // Frame RAM: registered read, one cycle after the enable is captured.
    logic [7:0] mem [4096];
    always @(posedge SCLK or posedge RST) begin
        if (RST) PIX_DATA <= 8'h00;
        else if (PIX_RE) PIX_DATA <= mem[PIX_ADDR];
    end

    int checks   = 0;
    int failures = 0;

    logic [7:0]  tx_bytes [MAXB];
    logic [7:0]  ebyte    [MAXB];
    logic [7:0]  rx_bytes [MAXB];
    logic [11:0] re_addr  [MAXB];
    bit          exp_re   [MAXC];
    bit          exp_done [MAXC];
    logic [11:0] exp_addr [MAXC];

    int cur_c = -1;
    bit act   = 1'b0;
    int re_count, done_count, done_byte;

    bit         m_tp;
    logic [5:0] m_row;
    logic [7:0] m_fcnt;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Expected per-cycle view of a transaction of nbits bits; index c is the
    // state seen after c sampling edges. Also advances the model registers.
    task automatic build_exp(input int nbits);
        int         nb;
        int         base;
        int         off;
        logic [7:0] st;
        logic [11:0] addr;
        nb = nbits / 8 + 1;
        for (int k = 0; k <= nb; k++) ebyte[k] = 8'h00;
        for (int c = 0; c <= nbits; c++) begin
            exp_re[c] = 1'b0; exp_done[c] = 1'b0; exp_addr[c] = 12'h000;
        end
        if (nbits < 8) return;
        case (tx_bytes[0])
            8'h9F: for (int k = 1; k <= nb; k++) ebyte[k] = 8'h64;
            8'h03: begin
                st = {m_tp, m_fcnt[6:0]};
                for (int k = 1; k <= nb; k++) ebyte[k] = st;
            end
            8'h02: begin
                if (nbits >= 24) begin
                    if (tx_bytes[1] == 8'h00) m_tp = tx_bytes[2][0];
                    else if (tx_bytes[1] == 8'h01) m_row = tx_bytes[2][5:0];
                end
            end
            8'h01: begin
                base = int'(m_row);
                off  = 0;
                for (int k = 1; 8 * k <= nbits; k++) begin
                    addr = 12'((base * 64 + off) % 4096);
                    if (!m_tp && (8 * k + 6 <= nbits)) begin
                        exp_re[8 * k + 6]   = 1'b1;
                        exp_addr[8 * k + 6] = addr;
                    end
                    if (8 * k + 8 <= nbits) begin
                        ebyte[k + 1] = m_tp ? {addr[9:6], addr[3:0]} : mem[addr];
                        if (off == 4095) begin
                            exp_done[8 * k + 8] = 1'b1;
                            m_fcnt = m_fcnt + 8'd1;
                            off  = 0;
                            base = int'(m_row);
                        end else begin
                            off++;
                        end
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(negedge SCLK) begin
        int c, k, j;
        if (act && cur_c >= 0) begin
            c = cur_c; k = c / 8; j = c % 8;
            check("miso", MISO, ebyte[k][7 - j]);
            rx_bytes[k][7 - j] = MISO;
            check("pix_re", PIX_RE, exp_re[c]);
            if (exp_re[c]) check("pix_addr", PIX_ADDR, exp_addr[c]);
            check("frame_done", FRAME_DONE, exp_done[c]);
            if (PIX_RE) begin
                re_addr[k] = PIX_ADDR;
                re_count++;
            end
            if (FRAME_DONE) begin
                done_count++;
                done_byte = k;
            end
        end
    end

    task automatic xfer(input int nbits);
        build_exp(nbits);
        re_count = 0; done_count = 0; done_byte = -1;
        for (int k = 0; k < 80; k++) begin
            rx_bytes[k] = 8'h00; re_addr[k] = 12'h000;
        end
        for (int c = 0; c < nbits; c++) begin
            @(posedge SCLK); #2;
            if (c == 0) begin
                CS_N = 1'b0; act = 1'b1;
            end
            MOSI  = tx_bytes[c / 8][7 - (c % 8)];
            cur_c = c;
        end
        @(posedge SCLK); #2;
        cur_c = nbits;
        @(negedge SCLK); #2;
        CS_N = 1'b1; act = 1'b0; MOSI = 1'b0; cur_c = -1;
        #1;
        check("tp_en", TP_EN, m_tp);
        check("row_start", ROW_START, m_row);
        check("idle_miso", MISO, 1'b0);
        check("idle_re", PIX_RE, 1'b0);
    endtask

    task automatic load(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        for (int k = 0; k < 80; k++) tx_bytes[k] = 8'($urandom);
        tx_bytes[0] = b0; tx_bytes[1] = b1; tx_bytes[2] = b2;
    endtask

    initial begin
        int r, nbytes;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
        for (int k = 0; k < MAXB; k++) tx_bytes[k] = 8'h00;
        m_tp = 1'b0; m_row = 6'd0; m_fcnt = 8'd0;

        RST = 1'b1;
        repeat (3) @(posedge SCLK);
        #2 RST = 1'b0;
        #1;
        check("rst_miso", MISO, 1'b0);
        check("rst_re", PIX_RE, 1'b0);
        check("rst_done", FRAME_DONE, 1'b0);
        check("rst_tp_en", TP_EN, 1'b0);
        check("rst_row_start", ROW_START, 6'd0);

        load(8'h9F, 8'hA5, 8'h3C); xfer(24);
        check("id_byte1", rx_bytes[1], 8'h64);
        check("id_byte2", rx_bytes[2], 8'h64);
        check("id_no_re", re_count, 0);

        load(8'h02, 8'h01, 8'h05); xfer(24);
        check("wr_row_start", ROW_START, 6'd5);
        load(8'h03, 8'h00, 8'h00); xfer(16);
        check("status_init", rx_bytes[1], 8'h00);
        load(8'h02, 8'h01, 8'h3F); xfer(21);
        check("partial_wr", ROW_START, 6'd5);

        load(8'h01, 8'h00, 8'h00); xfer(48);
        check("first_addr", re_addr[1], 12'h140);
        check("frame_b1", rx_bytes[1], 8'h00);
        check("frame_b2", rx_bytes[2], 8'h40);
        check("frame_b3", rx_bytes[3], 8'h41);
        check("frame_re_cnt", re_count, 5);

        load(8'h01, 8'h00, 8'h00); xfer(8 * 4099);
        check("full_done_cnt", done_count, 1);
        check("full_done_byte", done_byte, 4097);
        check("wrap_addr", re_addr[4097], 12'h140);
        check("wrap_byte", rx_bytes[4098], 8'h40);
        load(8'h03, 8'h00, 8'h00); xfer(16);
        check("status_fcnt", rx_bytes[1], 8'h01);

        load(8'h02, 8'h00, 8'h01); xfer(24);
        load(8'h02, 8'h01, 8'h00); xfer(24);
        load(8'h01, 8'h00, 8'h00); xfer(8 * 70);
        check("tp_no_re", re_count, 0);
        check("tp_b2", rx_bytes[2], 8'h00);
        check("tp_b3", rx_bytes[3], 8'h01);
        check("tp_b66", rx_bytes[66], 8'h10);
        load(8'h03, 8'h00, 8'h00); xfer(16);
        check("status_tp", rx_bytes[1], 8'h81);

        load(8'h02, 8'h00, 8'h00); xfer(24);
        load(8'h55, 8'h01, 8'h00); xfer(32);
        check("unk_no_re", re_count, 0);
        check("unk_b2", rx_bytes[2], 8'h00);
        load(8'h01, 8'h00, 8'h00); xfer(56);
        check("restart_re_cnt", re_count, 6);
        check("restart_b3", rx_bytes[3], 8'h01);

        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: load(8'h01, 8'h00, 8'h00);
                1: load(8'h02, 8'($urandom_range(0, 2)), 8'($urandom));
                2: load(8'h03, 8'h00, 8'h00);
                3: load(8'h9F, 8'h00, 8'h00);
                4: load(8'($urandom), 8'h00, 8'h00);
                default: load(8'h01, 8'h00, 8'h00);
            endcase
            nbytes = $urandom_range(1, 30);
            xfer(nbytes * 8 + $urandom_range(0, 7));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
